// File: rtl/alu_pkg.sv
// Shared ALU definitions: slice geometry, flag bundle and the flag-accumulator state type.
package alu_pkg;

    localparam int SLICE_W = 8;
    localparam int ALU_W   = 128;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DONE
    } flag_acc_state_t;

    typedef struct packed {
        logic c;
        logic z;
        logic s;
        logic o;
    } alu_flags_t;

endpackage

// File: rtl/alu_flag_accum.sv
// Collects per-slice c/z/s/o flags over NUM_SLICES passes of one 8-bit ALU slice and
// forms the full-width result flags, feeding each slice carry-out back as the next cin.
module alu_flag_accum
    import alu_pkg::*;
#(
    parameter int NUM_SLICES = 16,
    parameter int IDX_W      = $clog2(NUM_SLICES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             cin_init,
    input  logic             slice_valid,
    input  logic             slice_c,
    input  logic             slice_z,
    input  logic             slice_s,
    input  logic             slice_o,
    output logic             slice_ready,
    output logic [IDX_W-1:0] slice_idx,
    output logic             carry_to_slice,
    output logic             busy,
    output logic             flags_valid,
    output logic             c_flag,
    output logic             z_flag,
    output logic             s_flag,
    output logic             o_flag
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    flag_acc_state_t state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             z_acc_q, z_acc_d;
    alu_flags_t       flags_q, flags_d;
    logic             xfer;

    // Next-state logic: z accumulates across slices, c/s/o come from the MSB slice only.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        z_acc_d = z_acc_q;
        flags_d = flags_q;
        xfer    = (state_q == ACCUM) && slice_valid;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = ACCUM;
                    idx_d   = '0;
                    carry_d = cin_init;
                    z_acc_d = 1'b1;
                end
            end
            ACCUM: begin
                if (xfer) begin
                    z_acc_d = z_acc_q & slice_z;
                    carry_d = slice_c;
                    if (idx_q == LAST_IDX) begin
                        flags_d.c = slice_c;
                        flags_d.z = z_acc_q & slice_z;
                        flags_d.s = slice_s;
                        flags_d.o = slice_o;
                        state_d   = DONE;
                        idx_d     = '0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            z_acc_q <= 1'b0;
            flags_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            z_acc_q <= z_acc_d;
            flags_q <= flags_d;
        end
    end

    // Carry back to the slice comes straight from the register so the slice sees no
    // combinational loop through its own carry-out.
    assign carry_to_slice = carry_q;
    assign slice_idx      = idx_q;
    assign slice_ready    = (state_q == ACCUM);
    assign busy           = (state_q == ACCUM) || (state_q == DONE);
    assign flags_valid    = (state_q == DONE);
    assign c_flag         = flags_q.c;
    assign z_flag         = flags_q.z;
    assign s_flag         = flags_q.s;
    assign o_flag         = flags_q.o;

endmodule
